// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, capture FSM states and BCD constants shared by the display path
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0001100;
  localparam logic [3:0] BCD_INVALID = 4'hF;
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-low abcdefg pattern to BCD value, flagging anything not a digit
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] value,
  output logic       err
);
  // table lookup; unknown patterns read as BCD_INVALID
  always_comb begin
    case (seg_n)
      SEG_0:   value = 4'd0;
      SEG_1:   value = 4'd1;
      SEG_2:   value = 4'd2;
      SEG_3:   value = 4'd3;
      SEG_4:   value = 4'd4;
      SEG_5:   value = 4'd5;
      SEG_6:   value = 4'd6;
      SEG_7:   value = 4'd7;
      SEG_8:   value = 4'd8;
      SEG_9:   value = 4'd9;
      default: value = BCD_INVALID;
    endcase
    err = value == BCD_INVALID;
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: recovers four BCD digits from a multiplexed 7-seg bus; SEG7_DP_EN adds decimal-point capture
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an_n,
  input  logic [6:0] seg_n,
`ifdef SEG7_DP_EN
  input  logic       dp_n,
  output logic [3:0] dp,
`endif
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_err,
  output logic       frame_valid,
  output logic [3:0] stale
);
`ifdef SEG7_DP_EN
  localparam int W = 12;
  logic [W-1:0] bus;
  assign bus = {an_n, seg_n, dp_n};
`else
  localparam int W = 11;
  logic [W-1:0] bus;
  assign bus = {an_n, seg_n};
`endif
  localparam logic [7:0]  SC  = 8'(SETTLE_CYCLES);
  localparam logic [23:0] TMO = 24'(TIMEOUT_CYCLES);
  localparam state_t      GO  = (SETTLE_CYCLES == 1) ? CAPTURE : SETTLE;
  logic [W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0] an_s;
  logic [W-5:0] cmp_s, cmp_l_q;
  logic valid, changed;
  logic [1:0] sel, sel_l_q;
  logic [7:0] cnt_q;
  state_t state_q;
  logic [3:0] dec_val;
  logic dec_err;
  logic [3:0][3:0] digit_q, digit_d;
  logic [3:0] err_q, err_d, mask_q, mask_d;
  logic frame_q, frame_d;
  logic [3:0][23:0] tmo_q, tmo_d;
`ifdef SEG7_DP_EN
  logic [3:0] dp_q, dp_d;
  assign dp = dp_q;
`endif
  seg7_pattern_decode u_dec (.seg_n(cmp_l_q[W-5 -: 7]), .value(dec_val), .err(dec_err));
  // synchronized anode decode: valid only with exactly one active anode
  always_comb begin
    an_s = sync2_q[W-1 -: 4];
    cmp_s = sync2_q[W-5:0];
    valid = $countones(~an_s) == 1;
    sel = !an_s[0] ? 2'd0 : !an_s[1] ? 2'd1 : !an_s[2] ? 2'd2 : 2'd3;
    changed = sel != sel_l_q || cmp_s != cmp_l_q;
  end
  // settle/capture FSM; any change under a valid anode restarts the settle count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_l_q <= '0;
      cmp_l_q <= '1;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (valid) begin
          sel_l_q <= sel;
          cmp_l_q <= cmp_s;
          cnt_q <= 8'd1;
          state_q <= GO;
        end
        SETTLE: if (!valid) state_q <= IDLE;
        else if (changed) begin
          sel_l_q <= sel;
          cmp_l_q <= cmp_s;
          cnt_q <= 8'd1;
          state_q <= GO;
        end else begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q + 8'd1 == SC) state_q <= CAPTURE;
        end
        CAPTURE: state_q <= HOLD;
        HOLD: if (!valid) state_q <= IDLE;
        else if (changed) begin
          sel_l_q <= sel;
          cmp_l_q <= cmp_s;
          cnt_q <= 8'd1;
          state_q <= GO;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // capture write-back, frame tracking (set beats clear) and saturating refresh timeouts
  always_comb begin
    sync1_d = bus;
    sync2_d = sync1_q;
    digit_d = digit_q;
    err_d = err_q;
    frame_d = mask_q == 4'hF;
    mask_d = frame_d ? 4'h0 : mask_q;
`ifdef SEG7_DP_EN
    dp_d = dp_q;
`endif
    for (int i = 0; i < 4; i++) begin
      tmo_d[i] = tmo_q[i] == TMO ? TMO : tmo_q[i] + 24'd1;
      stale[i] = tmo_q[i] == TMO;
    end
    if (state_q == CAPTURE) begin
      digit_d[sel_l_q] = dec_val;
      err_d[sel_l_q] = dec_err;
      mask_d[sel_l_q] = 1'b1;
      tmo_d[sel_l_q] = '0;
`ifdef SEG7_DP_EN
      dp_d[sel_l_q] = ~cmp_l_q[0];
`endif
    end
  end
  // datapath registers; synchronizers reset to a blank display
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      digit_q <= {4{BCD_INVALID}};
      err_q <= '0;
      mask_q <= '0;
      frame_q <= 1'b0;
      tmo_q <= '0;
`ifdef SEG7_DP_EN
      dp_q <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      digit_q <= digit_d;
      err_q <= err_d;
      mask_q <= mask_d;
      frame_q <= frame_d;
      tmo_q <= tmo_d;
`ifdef SEG7_DP_EN
      dp_q <= dp_d;
`endif
    end
  end
  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];
  assign digit_err = err_q;
  assign frame_valid = frame_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed plus randomized checks of seg7_scan_capture against a run-length reference model
module tb_seg7_scan_capture;
  localparam int S = 4;
  localparam int T = 100;
`ifdef SEG7_DP_EN
  localparam bit DP = 1'b1;
`else
  localparam bit DP = 1'b0;
`endif
  localparam logic [6:0] PAT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] an_n = 4'hF;
  logic [6:0] seg_n = 7'h7F;
  logic dp_n = 1'b1;
  logic [3:0] digit0, digit1, digit2, digit3, digit_err, stale, dp_obs;
  logic frame_valid;
  int passed = 0, total = 0, fails = 0, fv_cnt = 0;
  logic [11:0] s1, s2, prev_v, pend_v;
  int run;
  bit pend;
  logic [3:0] m_dig [4];
  logic [3:0] m_err, m_mask, m_dp;
  logic m_fv;
  int m_tmo [4];
  always #5 clk = ~clk;
`ifdef SEG7_DP_EN
  logic [3:0] dp;
  assign dp_obs = dp;
`else
  assign dp_obs = 4'b0;
`endif
  seg7_scan_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .an_n(an_n), .seg_n(seg_n),
`ifdef SEG7_DP_EN
    .dp_n(dp_n), .dp(dp),
`endif
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .digit_err(digit_err), .frame_valid(frame_valid), .stale(stale)
  );
  function automatic bit an_ok(logic [3:0] a);
    return $countones(~a) == 1;
  endfunction
  function automatic int an_idx(logic [3:0] a);
    for (int i = 0; i < 4; i++) if (!a[i]) return i;
    return 0;
  endfunction
  function automatic logic [3:0] dec(logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == PAT[i]) return 4'(i);
    return 4'hF;
  endfunction
  // a capture lands one edge after a valid bus value has been seen for exactly S consecutive edges
  task automatic model_edge();
    logic [11:0] v, cv;
    logic [3:0] val;
    bit cap, fv;
    int k;
    if (!rst_n) begin
      s1 = '1; s2 = '1; prev_v = '1; pend_v = '1; run = 0; pend = 0;
      m_mask = 0; m_fv = 0; m_err = 0; m_dp = 0;
      for (int i = 0; i < 4; i++) begin m_dig[i] = 4'hF; m_tmo[i] = 0; end
    end else begin
      v = s2; cap = pend; cv = pend_v;
      fv = m_mask == 4'hF;
      if (fv) m_mask = 4'h0;
      for (int i = 0; i < 4; i++) if (m_tmo[i] < T) m_tmo[i]++;
      if (cap) begin
        k = an_idx(cv[11:8]);
        val = dec(cv[7:1]);
        m_dig[k] = val; m_err[k] = val == 4'hF; m_mask[k] = 1'b1; m_tmo[k] = 0; m_dp[k] = ~cv[0];
      end
      m_fv = fv;
      run = an_ok(v[11:8]) ? ((v == prev_v && run > 0) ? run + 1 : 1) : 0;
      pend = run == S; pend_v = v; prev_v = v;
      s2 = s1; s1 = {an_n, seg_n, DP ? dp_n : 1'b1};
    end
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] obs_all();
    return {3'b0, digit3, digit2, digit1, digit0, digit_err, frame_valid, stale, dp_obs};
  endfunction
  function automatic logic [31:0] exp_all();
    logic [3:0] st;
    for (int i = 0; i < 4; i++) st[i] = m_tmo[i] == T;
    return {3'b0, m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_err, m_fv, st, DP ? m_dp : 4'b0};
  endfunction
  task automatic step(logic [3:0] a, logic [6:0] s, int n);
    for (int i = 0; i < n; i++) begin
      an_n = a; seg_n = s;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (frame_valid) fv_cnt++;
      chk("cycle", obs_all(), exp_all());
    end
  endtask
  initial begin
    logic [3:0] a, pa;
    logic [6:0] s, ps;
    logic d, pd;
    step(4'hF, 7'h7F, 3);
    chk("reset", obs_all(), {3'b0, 16'hFFFF, 4'h0, 1'b0, 4'h0, 4'h0});
    rst_n = 1'b1;
    step(4'b1110, PAT[2], 6);
    chk("latency_pre", {28'b0, digit0}, 32'hF);
    step(4'b1110, PAT[2], 1);
    chk("latency_cap", {27'b0, digit0, digit_err[0]}, {27'b0, 4'd2, 1'b0});
    step(4'b1110, PAT[2], 13);
    chk("no_frame_single", fv_cnt, 0);
    step(4'b1110, PAT[3], 16);
    step(4'b1101, PAT[7], 16);
    step(4'b1011, PAT[0], 16);
    step(4'b0111, PAT[9], 7);
    chk("fv_at_cap", {27'b0, digit3, frame_valid}, {27'b0, 4'd9, 1'b0});
    step(4'b0111, PAT[9], 1);
    chk("fv_after_cap", {31'b0, frame_valid}, 32'd1);
    step(4'b0111, PAT[9], 8);
    chk("fv_once", fv_cnt, 1);
    chk("scan_digits", {16'b0, digit3, digit2, digit1, digit0}, {16'b0, 16'h9073});
    step(4'b1101, 7'h7F, 16);
    chk("blank_err", {27'b0, digit1, digit_err[1]}, {27'b0, 4'hF, 1'b1});
    step(4'b1101, PAT[1], 16);
    chk("err_clear", {27'b0, digit1, digit_err[1]}, {27'b0, 4'd1, 1'b0});
    for (int i = 0; i < 8; i++) step(4'b1110, PAT[5 + i % 2], 3);
    chk("glitch", {28'b0, digit0}, 32'd3);
    step(4'b1100, PAT[8], 16);
    chk("two_anodes", {16'b0, digit3, digit2, digit1, digit0}, {16'b0, 16'h9013});
    step(4'b1011, PAT[5], 6);
    chk("stale_set", {31'b0, stale[2]}, 32'd1);
    step(4'b1011, PAT[5], 1);
    chk("stale_clr_cap", {27'b0, digit2, stale[2]}, {27'b0, 4'd5, 1'b0});
    step(4'b1011, PAT[5], 9);
    step(4'b1110, PAT[4], 90);
    chk("stale_99", {31'b0, stale[2]}, 32'd0);
    step(4'b1110, PAT[4], 1);
    chk("stale_100", {31'b0, stale[2]}, 32'd1);
    step(4'b1011, PAT[8], 6);
    chk("stale_hold", {31'b0, stale[2]}, 32'd1);
    step(4'b1011, PAT[8], 1);
    chk("stale_recap", {27'b0, digit2, stale[2]}, {27'b0, 4'd8, 1'b0});
    step(4'b1110, PAT[1], 16);
    step(4'b1101, PAT[2], 16);
    rst_n = 1'b0;
    step(4'b1101, PAT[2], 1);
    chk("mid_reset", obs_all(), {3'b0, 16'hFFFF, 4'h0, 1'b0, 4'h0, 4'h0});
    rst_n = 1'b1;
    fv_cnt = 0;
    step(4'b1110, PAT[6], 16);
    step(4'b1101, PAT[4], 16);
    step(4'b1011, PAT[1], 16);
    step(4'b0111, PAT[8], 16);
    step(4'hF, 7'h7F, 4);
    chk("reset_frame_once", fv_cnt, 1);
    pa = 4'hF; ps = 7'h7F; pd = 1'b1;
    for (int n = 0; n < 250; n++) begin
      do begin
        case ($urandom_range(0, 9))
          7: a = 4'hF;
          8: a = 4'($urandom_range(0, 15));
          9: a = 4'h0;
          default: a = ~(4'b0001 << $urandom_range(0, 3));
        endcase
        s = $urandom_range(0, 9) < 8 ? PAT[$urandom_range(0, 9)] : 7'($urandom_range(0, 127));
        d = DP ? 1'($urandom_range(0, 1)) : 1'b1;
      end while (a == pa && s == ps && d == pd);
      dp_n = d;
      step(a, s, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : $urandom_range(7, 16));
      pa = a; ps = s; pd = d;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the BCD-to-7-segment display driver.
- Samples the multiplexed display bus (active-low anodes, active-low segments) and recovers the four BCD digits being shown.
- Flags any illegal segment patterns, signals each complete scan frame, and marks digits that are no longer being refreshed.
- Used as an in-design display monitor and as a checker for the reaction-timer display path.

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles the anode and segment values must hold before a sample is taken; legal range 1..255.
- TIMEOUT_CYCLES, 65535: cycles without a capture before a digit's stale bit is set; legal range 1..2^24-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- an_n  in  4  digit anodes, active-low; an_n[i]=0 selects digit i.
- seg_n  in  7  segments, active-low, bit6=a ... bit0=g.
- digit0..digit3  out  4 each  recovered BCD value per digit.
- digit_err  out  4  per-digit illegal-pattern flag from the last capture.
- frame_valid  out  1  one-cycle pulse when all four digits have been captured since the previous pulse.
- stale  out  4  per-digit refresh-timeout flag.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values:
  - digit0..3 = 4'hF, digit_err = 4'b0000, frame_valid = 0, stale = 4'b0000.
  - Captured mask = 0, all timeout counters = 0, FSM in IDLE.
  - Synchronizer flops = all ones (display blank).
- Input synchronization: an_n and seg_n each pass through a 2-flop synchronizer. All logic below uses the synchronized values.
- Anode is "valid" only when exactly one an_n bit is 0. Its index is sel.
- FSM:
  - IDLE: stay while the anode is invalid. When the anode becomes valid, latch sel and seg, load the settle counter with 1, go to SETTLE.
  - SETTLE: if the anode is invalid, go to IDLE. If sel or seg differs from the latched value, re-latch both, reload the counter with 1, stay. Otherwise increment; when the counter reaches SETTLE_CYCLES, go to CAPTURE.
  - CAPTURE (one cycle):
    - Write the decoded value to digit[sel] and update digit_err[sel].
    - Set mask[sel], clear stale[sel] and the timeout counter for sel.
    - Go to HOLD.
  - HOLD: stay while sel and seg are unchanged. If the anode becomes invalid, go to IDLE. If sel or seg changes with the anode still valid, latch the new values, reload the counter with 1, go to SETTLE.
    - A seg change under the same anode therefore triggers a recapture; this is intentional.
- Decode (active-low, abcdefg):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0001100=9.
  - Any other pattern gives value 4'hF with err=1.
- Latency: the digit output updates 2 + SETTLE_CYCLES + 1 cycles after a stable input change at the pins.
- frame_valid:
  - Registered; it pulses the cycle after the capture that completes mask=4'b1111.
  - The mask clears in that same cycle.
  - If a capture occurs in the clear cycle, its bit survives; set has priority over clear.
  - Recapturing an already-set digit does not advance the frame.
- Stale counters:
  - One per digit, saturating at TIMEOUT_CYCLES.
  - stale[i] = 1 while counter i equals TIMEOUT_CYCLES.
  - A capture of digit i clears its counter and its stale bit in the same cycle, overriding saturation.
- Reset mid-operation: all state returns to its reset value on the next edge. Partial frames are discarded.

Optional Feature:
- Macro: SEG7_DP_EN.
- When defined:
  - Adds input dp_n (1 bit, active-low decimal point) and output dp (4 bits, reset 0).
  - dp_n is synchronized and included in the SETTLE/HOLD change comparison.
  - dp[sel] = ~dp_n is written in CAPTURE.
- When undefined: the ports, flops and comparison term are absent, and behaviour is otherwise identical.

Decomposition:
- Package seg7_pkg holds:
  - The ten segment pattern localparams (7-bit, full width) shared with the driver.
  - The FSM state typedef enum (IDLE, SETTLE, CAPTURE, HOLD).
  - Constant BCD_INVALID = 4'hF.
- Sub-module seg7_pattern_decode: combinational seg_n[6:0] -> {value[3:0], err}, instantiated once.

Test Plan:
- Reset, then drive an_n=1110, seg_n=0010010 for 20 cycles -> digit0=2, digit_err[0]=0 at cycle 2+4+1=7; frame_valid stays 0.
- Scan digits 0..3 with 3, 7, 0, 9 at 16 cycles each -> digits = 3/7/0/9, and frame_valid pulses exactly once, one cycle after digit3 is captured.
- Hold seg_n=1111111 (blank) on an_n=1101 -> digit1=F, digit_err[1]=1. Then drive 1001111 -> digit1=1, err cleared.
- Glitch: change seg_n every 3 cycles with SETTLE_CYCLES=4 -> no capture and digit unchanged. Drive an_n=1100 (two digits selected) -> FSM stays IDLE.
- TIMEOUT_CYCLES=100; capture digit2, then select only digit0 -> stale[2]=1 exactly 100 cycles after digit2's capture. Recapturing digit2 clears stale[2] in the capture cycle.
- Assert rst_n=0 mid-frame after 2 captures -> all outputs return to reset values. A subsequent full scan yields a single frame_valid.
